// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes,
// FSM state encodings and request legality helpers.
package dmem_responder_pkg;

  localparam int DATA_W_DEF = 32;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    DR_IDLE   = 2'd0,
    DR_WAIT   = 2'd1,
    DR_ACCESS = 2'd2,
    DR_RESP   = 2'd3
  } dr_state_e;

  // Stores only have signed-form size codes; loads add the unsigned forms.
  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    if (write) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Byte accesses are always aligned; illegal codes are flagged elsewhere.
  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return !off[0];
      F3_W:        return off == 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the core's memory stage
// (master) and the data-memory responder (slave).
interface dmem_responder_if #(parameter int DATA_WIDTH = 32);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder_load_extend.sv
// Load data alignment: picks the addressed byte/half out of a word and
// sign- or zero-extends it according to funct3.
module load_extend
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            off,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select then extension; LW (and anything else) passes the word through.
  always_comb begin
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = word[{off[1], 4'b0000} +: 16];
    data   = word;
    case (funct3)
      F3_B:    data = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      F3_H:    data = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
      F3_BU:   data = DATA_WIDTH'(lane_b);
      F3_HU:   data = DATA_WIDTH'(lane_h);
      default: data = word;
    endcase
  end
endmodule

// File: rtl/dmem_responder.sv
// Stallable data-memory responder: one outstanding request, LATENCY wait
// cycles, byte/half/word access on a local word array, registered response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ADDR_BITS  = 8,
  parameter int LATENCY    = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = ADDR_BITS + 2;

  dr_state_e state, state_nx;
  logic [2:0] cnt, cnt_nx;

  logic                  write_q;
  logic [2:0]            f3_q;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  rdy_q, vld_q, err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] mem [0:2**ADDR_BITS-1];
  logic [ADDR_BITS-1:0]  idx;
  logic [DATA_WIDTH-1:0] rd_word, ld_data, st_data;
  logic [NB-1:0]         be;
  logic                  accept, req_err;

  // Address bits above the array are ignored, so the array aliases.
  logic unused_addr;
  assign unused_addr = ^bus.req_addr[DATA_WIDTH-1:AW];

  assign accept  = rdy_q && bus.req_valid;
  assign req_err = !f3_legal(bus.req_write, bus.req_funct3) ||
                   !f3_aligned(bus.req_funct3, bus.req_addr[1:0]);
  assign idx     = addr_q[AW-1:2];
  assign rd_word = mem[idx];

  assign bus.req_ready  = rdy_q;
  assign bus.resp_valid = vld_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
    .word   (rd_word),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  // Next-state and wait-counter logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      DR_IDLE: begin
        if (accept) begin
          if (req_err)           state_nx = DR_RESP;
          else if (LATENCY == 0) state_nx = DR_ACCESS;
          else begin
            state_nx = DR_WAIT;
            cnt_nx   = 3'(LATENCY - 1);
          end
        end
      end
      DR_WAIT: begin
        if (cnt == 3'd0) state_nx = DR_ACCESS;
        else             cnt_nx   = cnt - 3'd1;
      end
      DR_ACCESS: state_nx = DR_RESP;
      DR_RESP:   if (bus.resp_ready) state_nx = DR_IDLE;
      default:   state_nx = DR_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= DR_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Request capture on the accepting handshake.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= bus.req_write;
      f3_q    <= bus.req_funct3;
      addr_q  <= bus.req_addr[AW-1:0];
      wdata_q <= bus.req_wdata;
    end
  end

  // Handshake and response registers; ready/valid follow the next state so
  // neither has a combinational path from the bus inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdy_q <= (state_nx == DR_IDLE);
      vld_q <= (state_nx == DR_RESP);
      if (state == DR_IDLE && accept) begin
        err_q   <= req_err;
        rdata_q <= '0;
      end else if (state == DR_ACCESS) begin
        rdata_q <= write_q ? '0 : ld_data;
      end else if (state == DR_RESP && bus.resp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  // Store lane enables and lane-replicated store data.
  always_comb begin
    be      = '0;
    st_data = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be      = NB'(1) << addr_q[1:0];
        st_data = {NB{wdata_q[7:0]}};
      end
      2'b01: begin
        be      = NB'(3) << {addr_q[1], 1'b0};
        st_data = {(NB/2){wdata_q[15:0]}};
      end
      default: be = '1;
    endcase
  end

  // Memory write; a reset on the ACCESS edge suppresses the store.
  always_ff @(posedge clk) begin
    if (reset && state == DR_ACCESS && write_q) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for function,
// errors, backpressure and reset, plus a LATENCY=0 instance for timing.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if #(.DATA_WIDTH(32)) b0 ();
  dmem_responder_if #(.DATA_WIDTH(32)) b1 ();

  dmem_responder #(.DATA_WIDTH(32), .ADDR_BITS(8), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .bus(b0.slave));
  dmem_responder #(.DATA_WIDTH(32), .ADDR_BITS(8), .LATENCY(0)) dut_l0 (
    .clk(clk), .reset(reset), .bus(b1.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input logic w,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      b1.req_valid = v; b1.req_write = w; b1.req_funct3 = f3; b1.req_addr = a; b1.req_wdata = d;
    end else begin
      b0.req_valid = v; b0.req_write = w; b0.req_funct3 = f3; b0.req_addr = a; b0.req_wdata = d;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? b1.req_ready : b0.req_ready;
  endfunction

  function automatic logic vld(input bit sel);
    return sel ? b1.resp_valid : b0.resp_valid;
  endfunction

  // Issue one request and wait for its response without consuming it.
  // lat counts cycles from the accept edge to the first resp_valid cycle.
  task automatic do_req(input bit sel, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er, output int acc);
    int n;
    n = 0;
    drive(sel, 1'b1, w, f3, a, d);
    while (!rdy(sel) && n < 50) begin tick; n++; end
    if (!rdy(sel)) begin n_checks++; $display("FAIL accept_timeout addr=%h", a); end
    tick;
    acc = cyc;
    drive(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    lat = 1;
    while (!vld(sel) && lat < 50) begin tick; lat++; end
    rd = sel ? b1.resp_rdata : b0.resp_rdata;
    er = sel ? b1.resp_err : b0.resp_err;
  endtask

  // Request plus consuming handshake (resp_ready assumed high).
  task automatic xfer(input bit sel, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic er, output int acc);
    do_req(sel, w, f3, a, d, lat, rd, er, acc);
    tick;
  endtask

  task automatic test_reset;
    tick; tick; tick;
    n_checks++; if (b0.req_ready !== 1'b0) $display("FAIL rst_req_ready got %b want 0", b0.req_ready); else n_pass++;
    n_checks++; if (b0.resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", b0.resp_valid); else n_pass++;
    n_checks++; if (b0.resp_rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", b0.resp_rdata); else n_pass++;
    n_checks++; if (b0.resp_err !== 1'b0) $display("FAIL rst_err got %b want 0", b0.resp_err); else n_pass++;
    n_checks++; if (b1.req_ready !== 1'b0) $display("FAIL rst_l0_ready got %b want 0", b1.req_ready); else n_pass++;
    reset = 1'b1;
    tick;
    n_checks++; if (b0.req_ready !== 1'b1) $display("FAIL rel_req_ready got %b want 1", b0.req_ready); else n_pass++;
    n_checks++; if (b1.req_ready !== 1'b1) $display("FAIL rel_l0_ready got %b want 1", b1.req_ready); else n_pass++;
  endtask

  task automatic test_round_trip;
    int lat, acc0, acc1; logic [31:0] rd; logic er;
    xfer(0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, lat, rd, er, acc0);
    n_checks++; if (lat !== 4) $display("FAIL sw_latency got %0d want 4", lat); else n_pass++;
    n_checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL sw_resp got %h/%b want 0/0", rd, er); else n_pass++;
    xfer(0, 1'b0, F3_W, 32'h10, 32'h0, lat, rd, er, acc1);
    n_checks++; if (lat !== 4) $display("FAIL lw_latency got %0d want 4", lat); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL lw_data got %h/%b want deadbeef/0", rd, er); else n_pass++;
    n_checks++; if (acc1 - acc0 !== 5) $display("FAIL l2_period got %0d want 5", acc1 - acc0); else n_pass++;
  endtask

  task automatic test_subword;
    int lat, acc; logic [31:0] rd; logic er;
    xfer(0, 1'b1, F3_B, 32'h11, 32'hAAAAAA7F, lat, rd, er, acc);
    xfer(0, 1'b0, F3_B, 32'h11, 32'h0, lat, rd, er, acc);
    n_checks++; if (rd !== 32'h0000007F) $display("FAIL lb_11 got %h want 0000007f", rd); else n_pass++;
    xfer(0, 1'b0, F3_B, 32'h13, 32'h0, lat, rd, er, acc);
    n_checks++; if (rd !== 32'hFFFFFFDE) $display("FAIL lb_13 got %h want ffffffde", rd); else n_pass++;
    xfer(0, 1'b0, F3_BU, 32'h13, 32'h0, lat, rd, er, acc);
    n_checks++; if (rd !== 32'h000000DE) $display("FAIL lbu_13 got %h want 000000de", rd); else n_pass++;
    xfer(0, 1'b0, F3_H, 32'h12, 32'h0, lat, rd, er, acc);
    n_checks++; if (rd !== 32'hFFFFDEAD) $display("FAIL lh_12 got %h want ffffdead", rd); else n_pass++;
    xfer(0, 1'b0, F3_HU, 32'h12, 32'h0, lat, rd, er, acc);
    n_checks++; if (rd !== 32'h0000DEAD) $display("FAIL lhu_12 got %h want 0000dead", rd); else n_pass++;
    xfer(0, 1'b1, F3_H, 32'h10, 32'h00001234, lat, rd, er, acc);
    xfer(0, 1'b0, F3_W, 32'h10, 32'h0, lat, rd, er, acc);
    n_checks++; if (rd !== 32'hDEAD1234) $display("FAIL sh_10_word got %h want dead1234", rd); else n_pass++;
    xfer(0, 1'b1, F3_H, 32'h10, 32'h00007FEF, lat, rd, er, acc);
  endtask

  task automatic test_errors;
    int lat, acc; logic [31:0] rd; logic er;
    xfer(0, 1'b0, F3_W, 32'h12, 32'h0, lat, rd, er, acc);
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL lw_mis got %h/%b want 0/1", rd, er); else n_pass++;
    n_checks++; if (lat !== 1) $display("FAIL err_latency got %0d want 1", lat); else n_pass++;
    xfer(0, 1'b1, F3_H, 32'h13, 32'h0000BEEF, lat, rd, er, acc);
    n_checks++; if (er !== 1'b1) $display("FAIL sh_mis got err %b want 1", er); else n_pass++;
    xfer(0, 1'b0, F3_W, 32'h10, 32'h0, lat, rd, er, acc);
    n_checks++; if (rd !== 32'hDEAD7FEF || er !== 1'b0) $display("FAIL mem_after_err got %h/%b want dead7fef/0", rd, er); else n_pass++;
    xfer(0, 1'b0, 3'b011, 32'h10, 32'h0, lat, rd, er, acc);
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL ld_f3_011 got %h/%b want 0/1", rd, er); else n_pass++;
    xfer(0, 1'b1, F3_BU, 32'h10, 32'h0, lat, rd, er, acc);
    n_checks++; if (er !== 1'b1) $display("FAIL st_f3_100 got err %b want 1", er); else n_pass++;
    xfer(0, 1'b0, F3_W, 32'h10, 32'h0, lat, rd, er, acc);
    n_checks++; if (rd !== 32'hDEAD7FEF) $display("FAIL mem_after_st_err got %h want dead7fef", rd); else n_pass++;
  endtask

  task automatic test_backpressure_wrap;
    int lat, acc, bad; logic [31:0] rd; logic er;
    b0.resp_ready = 1'b0;
    do_req(0, 1'b0, F3_W, 32'h410, 32'h0, lat, rd, er, acc);
    n_checks++; if (rd !== 32'hDEAD7FEF) $display("FAIL wrap_ld got %h want dead7fef", rd); else n_pass++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (b0.resp_valid !== 1'b1 || b0.resp_rdata !== 32'hDEAD7FEF || b0.req_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL bp_stable got %0d bad cycles want 0", bad); else n_pass++;
    b0.resp_ready = 1'b1;
    tick;
    n_checks++; if (b0.resp_valid !== 1'b0 || b0.resp_rdata !== 32'h0) $display("FAIL bp_clear got %b/%h want 0/0", b0.resp_valid, b0.resp_rdata); else n_pass++;
    n_checks++; if (b0.req_ready !== 1'b1) $display("FAIL bp_ready_after got %b want 1", b0.req_ready); else n_pass++;
    xfer(0, 1'b1, F3_W, 32'h810, 32'h0BADF00D, lat, rd, er, acc);
    xfer(0, 1'b0, F3_W, 32'h10, 32'h0, lat, rd, er, acc);
    n_checks++; if (rd !== 32'h0BADF00D) $display("FAIL wrap_st got %h want 0badf00d", rd); else n_pass++;
  endtask

  task automatic test_reset_mid_store;
    int lat, acc, bad; logic [31:0] rd; logic er;
    xfer(0, 1'b1, F3_W, 32'h20, 32'h0, lat, rd, er, acc);
    // reset while in WAIT
    drive(0, 1'b1, 1'b1, F3_W, 32'h20, 32'h12345678);
    tick;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    reset = 1'b0;
    tick;
    n_checks++; if (b0.req_ready !== 1'b0 || b0.resp_valid !== 1'b0) $display("FAIL mid_rst_hs got %b/%b want 0/0", b0.req_ready, b0.resp_valid); else n_pass++;
    n_checks++; if (b0.resp_rdata !== 32'h0 || b0.resp_err !== 1'b0) $display("FAIL mid_rst_data got %h/%b want 0/0", b0.resp_rdata, b0.resp_err); else n_pass++;
    reset = 1'b1;
    tick;
    n_checks++; if (b0.req_ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", b0.req_ready); else n_pass++;
    bad = 0;
    for (int i = 0; i < 6; i++) begin tick; if (b0.resp_valid !== 1'b0) bad++; end
    n_checks++; if (bad !== 0) $display("FAIL mid_rst_no_resp got %0d want 0", bad); else n_pass++;
    xfer(0, 1'b0, F3_W, 32'h20, 32'h0, lat, rd, er, acc);
    n_checks++; if (rd !== 32'h0) $display("FAIL mid_rst_wait_mem got %h want 0", rd); else n_pass++;
    // reset on the ACCESS edge
    drive(0, 1'b1, 1'b1, F3_W, 32'h20, 32'hCAFEF00D);
    tick;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick; tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    xfer(0, 1'b0, F3_W, 32'h20, 32'h0, lat, rd, er, acc);
    n_checks++; if (rd !== 32'h0) $display("FAIL mid_rst_access_mem got %h want 0", rd); else n_pass++;
  endtask

  task automatic test_latency0;
    int lat, a0, a1, a2; logic [31:0] rd; logic er;
    xfer(1, 1'b1, F3_W, 32'h4, 32'h00000055, lat, rd, er, a0);
    n_checks++; if (lat !== 2) $display("FAIL l0_sw_latency got %0d want 2", lat); else n_pass++;
    xfer(1, 1'b0, F3_W, 32'h4, 32'h0, lat, rd, er, a1);
    n_checks++; if (lat !== 2 || rd !== 32'h55) $display("FAIL l0_lw got %0d/%h want 2/55", lat, rd); else n_pass++;
    xfer(1, 1'b0, F3_B, 32'h4, 32'h0, lat, rd, er, a2);
    n_checks++; if (rd !== 32'h55) $display("FAIL l0_lb got %h want 55", rd); else n_pass++;
    n_checks++; if (a1 - a0 !== 3 || a2 - a1 !== 3) $display("FAIL l0_period got %0d,%0d want 3,3", a1 - a0, a2 - a1); else n_pass++;
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    b0.resp_ready = 1'b1;
    b1.resp_ready = 1'b1;
    test_reset;
    test_round_trip;
    test_subword;
    test_errors;
    test_backpressure_wrap;
    test_reset_mid_store;
    test_latency0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
